// File: rtl/pe_add_f32_if.sv
// pe_add_f32_if: operand/result bundle for the pipelined binary32 adder
interface pe_add_f32_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        out_valid;
  modport master (output in_valid, a, b, input sum, out_valid);
  modport slave (input in_valid, a, b, output sum, out_valid);
endinterface

// File: rtl/pe_add_f32.sv
// pe_add_f32: 3-stage binary32 adder, round-nearest-even, subnormals flushed to zero
module pe_add_f32 (
  input logic         clk,
  input logic         rst,
  pe_add_f32_if.slave io
);
  logic        r0_valid, r1_valid, r2_valid, r_out_valid;
  logic [31:0] r0_a, r0_b, r_sum;
  logic        r1_special, r1_sign, r1_sub;
  logic [31:0] r1_spec_val;
  logic [7:0]  r1_exp;
  logic [23:0] r1_ml;
  logic [26:0] r1_al;
  logic        r2_special, r2_sign;
  logic [31:0] r2_spec_val;
  logic [7:0]  r2_exp;
  logic [27:0] r2_v;
  logic [4:0]  r2_lz;
  logic [7:0]  w_ea, w_eb, w_el, w_es, w_d;
  logic [22:0] w_fa, w_fb;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_nan, w_special, w_swap;
  logic [31:0] w_spec_val;
  logic [23:0] w_ml, w_ms;
  logic [4:0]  w_sh;
  logic [49:0] w_wide;
  logic [27:0] w_v;
  logic [4:0]  w_lz;
  logic [26:0] w_n;
  logic [23:0] w_sig;
  logic        w_g, w_r, w_s, w_up;
  logic [24:0] w_rs;
  logic signed [9:0] w_e1, w_e2;
  logic [31:0] w_res;
  assign w_ea = r0_a[30:23];
  assign w_eb = r0_b[30:23];
  assign w_fa = r0_a[22:0];
  assign w_fb = r0_b[22:0];
  assign w_a_zero = w_ea == 8'd0;
  assign w_b_zero = w_eb == 8'd0;
  assign w_a_inf = &w_ea && w_fa == 23'd0;
  assign w_b_inf = &w_eb && w_fb == 23'd0;
  assign w_nan = (&w_ea && |w_fa) || (&w_eb && |w_fb) || (w_a_inf && w_b_inf && r0_a[31] != r0_b[31]);
  assign w_special = w_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_spec_val = w_nan ? 32'h7FC00000 :
                      w_a_inf ? {r0_a[31], 8'hFF, 23'd0} :
                      w_b_inf ? {r0_b[31], 8'hFF, 23'd0} :
                      (w_a_zero && w_b_zero) ? {r0_a[31] & r0_b[31], 31'd0} :
                      w_a_zero ? r0_b : r0_a;
  // exp/frac are contiguous, so a 31-bit compare orders magnitudes
  assign w_swap = r0_b[30:0] > r0_a[30:0];
  assign w_el = w_swap ? w_eb : w_ea;
  assign w_es = w_swap ? w_ea : w_eb;
  assign w_ml = w_swap ? {1'b1, w_fb} : {1'b1, w_fa};
  assign w_ms = w_swap ? {1'b1, w_fa} : {1'b1, w_fb};
  assign w_d = w_el - w_es;
  assign w_sh = w_d >= 8'd26 ? 5'd26 : w_d[4:0];
  assign w_wide = {w_ms, 26'd0} >> w_sh;
  assign w_v = r1_sub ? {1'b0, r1_ml, 3'd0} - {1'b0, r1_al} : {1'b0, r1_ml, 3'd0} + {1'b0, r1_al};
  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) if (w_v[i]) w_lz = 5'(26 - i);
  end
  assign w_n = r2_v[26:0] << r2_lz;
  assign w_sig = r2_v[27] ? r2_v[27:4] : w_n[26:3];
  assign w_g = r2_v[27] ? r2_v[3] : w_n[2];
  assign w_r = r2_v[27] ? r2_v[2] : w_n[1];
  assign w_s = r2_v[27] ? |r2_v[1:0] : w_n[0];
  assign w_up = w_g & (w_r | w_s | w_sig[0]);
  assign w_rs = {1'b0, w_sig} + {24'd0, w_up};
  assign w_e1 = r2_v[27] ? $signed({2'b00, r2_exp}) + 10'sd1 : $signed({2'b00, r2_exp}) - $signed({5'd0, r2_lz});
  assign w_e2 = w_rs[24] ? w_e1 + 10'sd1 : w_e1;
  assign w_res = r2_special ? r2_spec_val :
                 r2_v == 28'd0 ? 32'd0 :
                 w_e2 >= 10'sd255 ? {r2_sign, 8'hFF, 23'd0} :
                 w_e2 <= 10'sd0 ? {r2_sign, 31'd0} :
                 {r2_sign, w_e2[7:0], w_rs[24] ? w_rs[23:1] : w_rs[22:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum <= 32'd0;
    end else begin
      r0_valid <= io.in_valid;
      r1_valid <= r0_valid;
      r2_valid <= r1_valid;
      r_out_valid <= r2_valid;
      if (r2_valid) r_sum <= w_res;
    end
  end
  always_ff @(posedge clk) begin
    r0_a <= io.a;
    r0_b <= io.b;
    r1_special <= w_special;
    r1_spec_val <= w_spec_val;
    r1_sign <= w_swap ? r0_b[31] : r0_a[31];
    r1_sub <= r0_a[31] ^ r0_b[31];
    r1_exp <= w_el;
    r1_ml <= w_ml;
    r1_al <= {w_wide[49:24], |w_wide[23:0]};
    r2_special <= r1_special;
    r2_spec_val <= r1_spec_val;
    r2_sign <= r1_sign;
    r2_exp <= r1_exp;
    r2_v <= w_v;
    r2_lz <= w_lz;
  end
  assign io.sum = r_sum;
  assign io.out_valid = r_out_valid;
endmodule

// File: tb/tb_pe_add_f32.sv
// tb_pe_add_f32: scoreboard bench for pe_add_f32, exact-arithmetic reference model
module tb_pe_add_f32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pe_add_f32_if io();
  pe_add_f32 dut (.clk(clk), .rst(rst), .io(io));
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } item_t;
  item_t sb[$];
  item_t mon_it;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // exact sum on a wide integer grid, then one RNE rounding to 24 bits
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, emin, p, k, e;
    logic [299:0] ma, mb, mag, q, rem, half;
    logic sign;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return a[31] == b[31] ? a : 32'h7FC00000;
    if (ea == 255) return a;
    if (eb == 255) return b;
    if (ea == 0 && eb == 0) return (a[31] && b[31]) ? 32'h80000000 : 32'h0;
    if (ea == 0) return b;
    if (eb == 0) return a;
    emin = ea < eb ? ea : eb;
    ma = 300'({1'b1, a[22:0]}) << (ea - emin);
    mb = 300'({1'b1, b[22:0]}) << (eb - emin);
    if (a[31] == b[31]) begin
      mag = ma + mb;
      sign = a[31];
    end else if (ma > mb) begin
      mag = ma - mb;
      sign = a[31];
    end else if (mb > ma) begin
      mag = mb - ma;
      sign = b[31];
    end else return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = emin + p - 23;
    if (p > 23) begin
      k = p - 23;
      q = mag >> k;
      rem = mag & ((300'd1 << k) - 300'd1);
      half = 300'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'd1;
      if (q[24]) begin
        q = q >> 1;
        e++;
      end
    end else q = mag << (23 - p);
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    if (e <= 0) return {sign, 31'd0};
    return {sign, 8'(e), q[22:0]};
  endfunction
  function automatic logic [31:0] rnd_op(input logic [31:0] other);
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 7))
      3: x[30:23] = other[30:23] + 8'($urandom_range(0, 3));
      4: x = {~other[31], other[30:4], 4'($urandom)};
      5: x[30:23] = 8'd0;
      6: x[30:23] = 8'hFF;
      7: x[30:23] = $urandom_range(0, 1) ? 8'd254 : 8'd1;
      default: ;
    endcase
    return x;
  endfunction
  always @(negedge clk) begin
    if (io.out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got sum=%h at cycle %0d, required no output", io.sum, cyc);
      end else begin
        mon_it = sb.pop_front();
        if (io.sum !== mon_it.exp) begin
          errors++;
          $display("FAIL sum %h+%h: got %h, required %h", mon_it.a, mon_it.b, io.sum, mon_it.exp);
        end
        checks++;
        if (cyc != mon_it.cyc + 3) begin
          errors++;
          $display("FAIL latency %h+%h: got output at cycle %0d, required %0d", mon_it.a, mon_it.b, cyc, mon_it.cyc + 3);
        end
      end
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    item_t it;
    io.in_valid = 1'b1;
    io.a = a;
    io.b = b;
    it.a = a;
    it.b = b;
    it.exp = exp;
    it.cyc = cyc + 1;
    sb.push_back(it);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask
  task automatic check_idle(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      checks++;
      if (io.out_valid !== 1'b0 || io.sum !== 32'h0) begin
        errors++;
        $display("FAIL %s: got out_valid=%b sum=%h, required out_valid=0 sum=00000000", tag, io.out_valid, io.sum);
      end
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask
  logic [31:0] dir_a[16] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h80000000,
                             32'h40400000, 32'h3F800000, 32'h3F800001, 32'h3F800000,
                             32'h7F800000, 32'h7FC00001, 32'h7F7FFFFF, 32'h00000050,
                             32'h3F800000, 32'h00800000, 32'hFF800000, 32'hFF7FFFFF};
  logic [31:0] dir_b[16] = '{32'h40000000, 32'h3F800000, 32'hBF800000, 32'h80000000,
                             32'hBF800000, 32'h33800000, 32'h33800000, 32'h33800001,
                             32'hFF800000, 32'h3F800000, 32'h7F7FFFFF, 32'h00000004,
                             32'h80000001, 32'h80800001, 32'hFF800000, 32'hFF7FFFFF};
  logic [31:0] dir_e[16] = '{32'h40400000, 32'h40400000, 32'h00000000, 32'h80000000,
                             32'h40000000, 32'h3F800000, 32'h3F800002, 32'h3F800001,
                             32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                             32'h3F800000, 32'h80000000, 32'hFF800000, 32'hFF800000};
  initial begin
    logic [31:0] ra, rb;
    io.in_valid = 1'b0;
    io.a = 32'h0;
    io.b = 32'h0;
    rst = 1'b1;
    check_idle(2, "reset");
    rst = 1'b0;
    check_idle(3, "idle");
    issue(dir_a[0], dir_b[0], dir_e[0]);
    drain();
    for (int i = 1; i < 16; i++) issue(dir_a[i], dir_b[i], dir_e[i]);
    drain();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        ra = $urandom;
        rb = rnd_op(ra);
        if ($urandom_range(0, 1) == 1) issue(ra, rb, ref_add(ra, rb));
        else issue(rb, ra, ref_add(rb, ra));
      end
    end
    drain();
    issue(32'h3F800000, 32'h40000000, 32'h40400000);
    rst = 1'b1;
    check_idle(1, "reset_midflight");
    sb.delete();
    rst = 1'b0;
    check_idle(5, "no_output_after_reset");
    issue(32'h40400000, 32'hBF800000, 32'h40000000);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
